// File: rtl/corr_frame_rx_pkg.sv
// Shared definitions for the correlator frame link: receiver states, trailer
// byte offsets and the frame-size formulas used by both transmit and receive sides.
package corr_frame_rx_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } rx_state_t;

  localparam int TRL_LINE0       = 0;
  localparam int TRL_DELAY_LINES = 4;
  localparam int TRL_NUM_INPUTS  = 5;
  localparam int TRL_RESOLUTION  = 6;
  localparam int TRL_PAD         = 7;
  localparam int TRL_BYTES       = 8;

  function automatic int num_correlators(input int num_inputs);
    return num_inputs * (num_inputs - 1) / 2;
  endfunction

  function automatic int n_words(input int num_inputs, input int delay_lines);
    return num_correlators(num_inputs) * delay_lines + num_inputs;
  endfunction

  function automatic int frame_bytes(input int num_inputs, input int delay_lines,
                                     input int resolution);
    return n_words(num_inputs, delay_lines) * resolution / 8 + TRL_BYTES;
  endfunction

endpackage

// File: rtl/corr_frame_rx_gap_timer.sv
// Saturating idle-cycle counter; gap_hit marks the cycle that completes a gap,
// armed stays set from then until the receiver consumes it with take.
module corr_frame_rx_gap_timer #(
  parameter int GAP_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_valid,
  input  logic take,
  output logic gap_hit,
  output logic armed
);

  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] SAT       = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] LAST_IDLE = CW'(GAP_CYCLES - 1);

  logic [CW-1:0] idle_cnt;

  assign gap_hit = !rx_valid && (idle_cnt == LAST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      if (rx_valid)
        idle_cnt <= '0;
      else if (idle_cnt != SAT)
        idle_cnt <= idle_cnt + 1'b1;

      if (gap_hit)
        armed <= 1'b1;
      else if (take)
        armed <= 1'b0;
    end
  end

endmodule

// File: rtl/corr_frame_rx.sv
// Reassembles little-endian counter words from a UART byte stream delimited by
// idle gaps, validates the 8-byte trailer and publishes its header fields.
module corr_frame_rx
  import corr_frame_rx_pkg::*;
#(
  parameter int RESOLUTION  = 8,
  parameter int MAX_DELAY   = 50,
  parameter int DELAY_LINES = MAX_DELAY | 1,
  parameter int NUM_INPUTS  = 8,
  parameter int GAP_CYCLES  = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [RESOLUTION-1:0] cnt_data,
  output logic [15:0]           cnt_index,
  output logic                  cnt_valid,
  output logic [3:0]            active_line,
  output logic [7:0]            hdr_delay_lines,
  output logic [7:0]            hdr_num_inputs,
  output logic [7:0]            hdr_resolution,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int          N_WORDS   = n_words(NUM_INPUTS, DELAY_LINES);
  localparam int          BPW       = RESOLUTION / 8;
  localparam logic        LAST_BYTE = 1'(BPW - 1);
  localparam logic [15:0] LAST_WORD = 16'(N_WORDS - 1);
  localparam logic [7:0]  DL8       = 8'(DELAY_LINES);
  localparam logic [7:0]  NI8       = 8'(NUM_INPUTS);
  localparam logic [7:0]  RES8      = 8'(RESOLUTION);

  rx_state_t             state, state_nxt;
  logic                  byte_cnt, byte_cnt_nxt;
  logic [15:0]           word_cnt, word_cnt_nxt;
  logic [RESOLUTION-1:0] word_acc, word_acc_nxt, acc_shift;
  logic [7:0][7:0]       trl, trl_nxt;
  logic [2:0]            tr_cnt, tr_cnt_nxt;
  logic                  trl_ok;
  logic                  take, gap_hit, armed;

  logic                  cnt_valid_nxt, frame_done_nxt, frame_err_nxt;
  logic [RESOLUTION-1:0] cnt_data_nxt;
  logic [15:0]           cnt_index_nxt;
  logic [3:0]            active_line_nxt;
  logic [7:0]            hdr_dl_nxt, hdr_ni_nxt, hdr_res_nxt;

  // The byte that follows an armed gap is already payload byte 0.
  assign take = (state == SYNC) && armed && rx_valid;

  // Bytes enter at the top, so after the last byte the LSB byte sits lowest.
  assign acc_shift = RESOLUTION'({rx_data, word_acc} >> 8);

  corr_frame_rx_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) gap_timer (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .take     (take),
    .gap_hit  (gap_hit),
    .armed    (armed)
  );

  always_comb begin
    state_nxt       = state;
    byte_cnt_nxt    = byte_cnt;
    word_cnt_nxt    = word_cnt;
    word_acc_nxt    = word_acc;
    trl_nxt         = trl;
    tr_cnt_nxt      = tr_cnt;
    trl_ok          = 1'b0;
    cnt_valid_nxt   = 1'b0;
    cnt_data_nxt    = cnt_data;
    cnt_index_nxt   = cnt_index;
    frame_done_nxt  = 1'b0;
    frame_err_nxt   = 1'b0;
    active_line_nxt = active_line;
    hdr_dl_nxt      = hdr_delay_lines;
    hdr_ni_nxt      = hdr_num_inputs;
    hdr_res_nxt     = hdr_resolution;

    case (state)
      SYNC: begin
        if (take)
          state_nxt = PAYLOAD;
      end
      PAYLOAD, TRAILER: begin
        if (gap_hit) begin
          state_nxt     = SYNC;
          byte_cnt_nxt  = 1'b0;
          word_cnt_nxt  = '0;
          tr_cnt_nxt    = '0;
          frame_err_nxt = 1'b1;
        end
      end
      default: state_nxt = SYNC;
    endcase

    if (take || (state == PAYLOAD && rx_valid)) begin
      word_acc_nxt = acc_shift;
      if (byte_cnt == LAST_BYTE) begin
        byte_cnt_nxt  = 1'b0;
        cnt_valid_nxt = 1'b1;
        cnt_data_nxt  = acc_shift;
        cnt_index_nxt = word_cnt;
        if (word_cnt == LAST_WORD) begin
          word_cnt_nxt = '0;
          tr_cnt_nxt   = '0;
          state_nxt    = TRAILER;
        end else begin
          word_cnt_nxt = word_cnt + 16'd1;
        end
      end else begin
        byte_cnt_nxt = byte_cnt + 1'b1;
      end
    end

    if (state == TRAILER && rx_valid) begin
      trl_nxt[tr_cnt] = rx_data;
      tr_cnt_nxt      = tr_cnt + 3'd1;
      if (tr_cnt == 3'(TRL_BYTES - 1)) begin
        trl_ok = (trl_nxt[TRL_LINE0][7:4] == 4'd0) &&
                 (trl_nxt[TRL_LINE0 + 1] == 8'd0) &&
                 (trl_nxt[TRL_LINE0 + 2] == 8'd0) &&
                 (trl_nxt[TRL_LINE0 + 3] == 8'd0) &&
                 (trl_nxt[TRL_DELAY_LINES] == DL8) &&
                 (trl_nxt[TRL_NUM_INPUTS] == NI8) &&
                 (trl_nxt[TRL_RESOLUTION] == RES8) &&
                 (trl_nxt[TRL_PAD] == 8'd0);
        state_nxt  = SYNC;
        tr_cnt_nxt = '0;
        if (trl_ok) begin
          active_line_nxt = trl_nxt[TRL_LINE0][3:0];
          hdr_dl_nxt      = trl_nxt[TRL_DELAY_LINES];
          hdr_ni_nxt      = trl_nxt[TRL_NUM_INPUTS];
          hdr_res_nxt     = trl_nxt[TRL_RESOLUTION];
          frame_done_nxt  = 1'b1;
        end else begin
          frame_err_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= SYNC;
      byte_cnt        <= 1'b0;
      word_cnt        <= '0;
      word_acc        <= '0;
      trl             <= '0;
      tr_cnt          <= '0;
      cnt_valid       <= 1'b0;
      cnt_data        <= '0;
      cnt_index       <= '0;
      frame_done      <= 1'b0;
      frame_err       <= 1'b0;
      active_line     <= '0;
      hdr_delay_lines <= '0;
      hdr_num_inputs  <= '0;
      hdr_resolution  <= '0;
    end else begin
      state           <= state_nxt;
      byte_cnt        <= byte_cnt_nxt;
      word_cnt        <= word_cnt_nxt;
      word_acc        <= word_acc_nxt;
      trl             <= trl_nxt;
      tr_cnt          <= tr_cnt_nxt;
      cnt_valid       <= cnt_valid_nxt;
      cnt_data        <= cnt_data_nxt;
      cnt_index       <= cnt_index_nxt;
      frame_done      <= frame_done_nxt;
      frame_err       <= frame_err_nxt;
      active_line     <= active_line_nxt;
      hdr_delay_lines <= hdr_dl_nxt;
      hdr_num_inputs  <= hdr_ni_nxt;
      hdr_resolution  <= hdr_res_nxt;
    end
  end

endmodule

// File: tb/tb_corr_frame_rx.sv
// Directed bench: default 8-bit receiver plus a small 16-bit receiver with a short gap.
module tb_corr_frame_rx;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] a_rx_data, b_rx_data;
  logic       a_rx_valid, b_rx_valid;

  logic [7:0]  a_cnt_data;
  logic [15:0] a_cnt_index;
  logic        a_cnt_valid, a_done, a_err;
  logic [3:0]  a_line;
  logic [7:0]  a_hdr_dl, a_hdr_ni, a_hdr_res;

  logic [15:0] b_cnt_data;
  logic [15:0] b_cnt_index;
  logic        b_cnt_valid, b_done, b_err;
  logic [3:0]  b_line;
  logic [7:0]  b_hdr_dl, b_hdr_ni, b_hdr_res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  corr_frame_rx dut_a (
    .clk(clk), .reset(reset), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .cnt_data(a_cnt_data), .cnt_index(a_cnt_index), .cnt_valid(a_cnt_valid),
    .active_line(a_line), .hdr_delay_lines(a_hdr_dl), .hdr_num_inputs(a_hdr_ni),
    .hdr_resolution(a_hdr_res), .frame_done(a_done), .frame_err(a_err)
  );

  corr_frame_rx #(.RESOLUTION(16), .MAX_DELAY(2), .NUM_INPUTS(2), .GAP_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .cnt_data(b_cnt_data), .cnt_index(b_cnt_index), .cnt_valid(b_cnt_valid),
    .active_line(b_line), .hdr_delay_lines(b_hdr_dl), .hdr_num_inputs(b_hdr_ni),
    .hdr_resolution(b_hdr_res), .frame_done(b_done), .frame_err(b_err)
  );

  // Monitor A: every word k must carry index k and data k mod 256.
  int          a_nval = 0, a_ndone = 0, a_nerr = 0, a_both = 0, a_seqbad = 0;
  logic [15:0] a_exp = '0;
  always @(negedge clk) begin
    if (reset) begin
      a_exp <= '0;
    end else begin
      if (a_cnt_valid) begin
        if (a_cnt_index != a_exp || a_cnt_data != a_exp[7:0])
          a_seqbad <= a_seqbad + 1;
        a_nval <= a_nval + 1;
        a_exp  <= a_exp + 16'd1;
      end
      if (a_done) a_ndone <= a_ndone + 1;
      if (a_err)  a_nerr  <= a_nerr + 1;
      if (a_done || a_err) a_exp <= '0;
      if (a_done && a_err) a_both <= a_both + 1;
    end
  end

  int          b_nval = 0, b_ndone = 0, b_nerr = 0, b_both = 0;
  logic [2:0]  b_slot = '0;
  logic [15:0] b_dat [0:7];
  logic [15:0] b_idx [0:7];
  always @(negedge clk) begin
    if (!reset) begin
      if (b_cnt_valid) begin
        b_dat[b_slot] <= b_cnt_data;
        b_idx[b_slot] <= b_cnt_index;
        b_slot        <= b_slot + 3'd1;
        b_nval        <= b_nval + 1;
      end
      if (b_done) b_ndone <= b_ndone + 1;
      if (b_err)  b_nerr  <= b_nerr + 1;
      if (b_done && b_err) b_both <= b_both + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_byte(input logic [7:0] b);
    @(negedge clk);
    a_rx_data  = b;
    a_rx_valid = 1'b1;
  endtask

  task automatic a_idle(input int n);
    @(negedge clk);
    a_rx_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic a_payload(input int n);
    for (int k = 0; k < n; k++) a_byte(8'(k));
  endtask

  task automatic a_trailer(input logic [7:0] line, input logic [7:0] ni);
    a_byte(line); a_byte(8'h00); a_byte(8'h00); a_byte(8'h00);
    a_byte(8'h33); a_byte(ni); a_byte(8'h08); a_byte(8'h00);
  endtask

  task automatic b_byte(input logic [7:0] b);
    @(negedge clk);
    b_rx_data  = b;
    b_rx_valid = 1'b1;
  endtask

  task automatic b_idle(input int n);
    @(negedge clk);
    b_rx_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic b_frame(input logic [7:0] line);
    logic [15:0] w [0:4];
    w[0] = 16'h1234; w[1] = 16'habcd; w[2] = 16'h0001; w[3] = 16'hff00; w[4] = 16'h5a5a;
    for (int k = 0; k < 5; k++) begin
      b_byte(w[k][7:0]);
      b_byte(w[k][15:8]);
    end
    b_byte(line); b_byte(8'h00); b_byte(8'h00); b_byte(8'h00);
    b_byte(8'h03); b_byte(8'h02); b_byte(8'h10); b_byte(8'h00);
  endtask

  int v0, d0, e0;

  initial begin
    // rx_valid is held high during reset: reset must win.
    reset      = 1'b1;
    a_rx_data  = 8'h55;
    a_rx_valid = 1'b1;
    b_rx_data  = 8'h00;
    b_rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset      = 1'b0;
    a_rx_valid = 1'b0;
    check("rst_cnt_valid", 32'(a_cnt_valid), 0);
    check("rst_cnt_data", 32'(a_cnt_data), 0);
    check("rst_cnt_index", 32'(a_cnt_index), 0);
    check("rst_active_line", 32'(a_line), 0);
    check("rst_hdr_dl", 32'(a_hdr_dl), 0);
    check("rst_hdr_ni", 32'(a_hdr_ni), 0);
    check("rst_hdr_res", 32'(a_hdr_res), 0);
    check("rst_done_err", 32'({a_done, a_err}), 0);
    check("rst_b_cnt_data", 32'(b_cnt_data), 0);

    // A whole frame before any gap is ignored.
    v0 = a_nval; d0 = a_ndone;
    a_payload(1436); a_trailer(8'h03, 8'h08); a_idle(5);
    check("pregap_nvalid", a_nval - v0, 0);
    check("pregap_done", a_ndone - d0, 0);

    // Good default frame.
    a_idle(4100);
    v0 = a_nval; d0 = a_ndone; e0 = a_nerr;
    a_payload(1436); a_trailer(8'h03, 8'h08); a_idle(5);
    check("f1_nvalid", a_nval - v0, 1436);
    check("f1_done", a_ndone - d0, 1);
    check("f1_err", a_nerr - e0, 0);
    check("f1_active_line", 32'(a_line), 3);
    check("f1_hdr_dl", 32'(a_hdr_dl), 'h33);
    check("f1_hdr_ni", 32'(a_hdr_ni), 8);
    check("f1_hdr_res", 32'(a_hdr_res), 8);
    check("f1_hold_index", 32'(a_cnt_index), 1435);
    check("f1_hold_data", 32'(a_cnt_data), 'h9b);

    // Bad NUM_INPUTS in trailer: error, header kept.
    a_idle(4100);
    d0 = a_ndone; e0 = a_nerr;
    a_payload(1436); a_trailer(8'h05, 8'h07); a_idle(5);
    check("badtrl_err", a_nerr - e0, 1);
    check("badtrl_done", a_ndone - d0, 0);
    check("badtrl_line_kept", 32'(a_line), 3);
    check("badtrl_ni_kept", 32'(a_hdr_ni), 8);

    // Truncated frame then an immediate good frame.
    a_idle(4100);
    v0 = a_nval; d0 = a_ndone; e0 = a_nerr;
    a_payload(700); a_idle(4100);
    check("trunc_err", a_nerr - e0, 1);
    check("trunc_nvalid", a_nval - v0, 700);
    check("trunc_done", a_ndone - d0, 0);
    v0 = a_nval;
    a_payload(1436); a_trailer(8'h09, 8'h08); a_idle(5);
    check("after_trunc_done", a_ndone - d0, 1);
    check("after_trunc_nvalid", a_nval - v0, 1436);
    check("after_trunc_line", 32'(a_line), 9);

    // Reset mid-frame.
    a_idle(4100);
    d0 = a_ndone; e0 = a_nerr;
    a_payload(500);
    @(negedge clk);
    reset      = 1'b1;
    a_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("midrst_cnt_index", 32'(a_cnt_index), 0);
    check("midrst_cnt_data", 32'(a_cnt_data), 0);
    check("midrst_line", 32'(a_line), 0);
    check("midrst_hdr_dl", 32'(a_hdr_dl), 0);
    check("midrst_err", a_nerr - e0, 0);
    a_idle(4100);
    v0 = a_nval;
    a_payload(1436); a_trailer(8'h0c, 8'h08); a_idle(5);
    check("postrst_done", a_ndone - d0, 1);
    check("postrst_err", a_nerr - e0, 0);
    check("postrst_nvalid", a_nval - v0, 1436);
    check("postrst_line", 32'(a_line), 12);
    check("a_word_sequence", a_seqbad, 0);

    // 16-bit receiver.
    b_idle(20);
    b_frame(8'h03); b_idle(5);
    check("b_nvalid", b_nval, 5);
    check("b_word0_data", 32'(b_dat[0]), 'h1234);
    check("b_word0_index", 32'(b_idx[0]), 0);
    check("b_word4_data", 32'(b_dat[4]), 'h5a5a);
    check("b_word4_index", 32'(b_idx[4]), 4);
    check("b_done", b_ndone, 1);
    check("b_hdr_dl", 32'(b_hdr_dl), 3);
    check("b_hdr_ni", 32'(b_hdr_ni), 2);
    check("b_hdr_res", 32'(b_hdr_res), 16);
    check("b_line", 32'(b_line), 3);

    // Word split by a gap yields no word and an error; next frame is clean.
    b_idle(20);
    v0 = b_nval; e0 = b_nerr; d0 = b_ndone;
    b_byte(8'h34); b_idle(20);
    check("b_split_nvalid", b_nval - v0, 0);
    check("b_split_err", b_nerr - e0, 1);
    check("b_split_hold", 32'(b_cnt_data), 'h5a5a);
    b_frame(8'h07); b_idle(5);
    check("b_after_split_done", b_ndone - d0, 1);
    check("b_after_split_nvalid", b_nval - v0, 5);
    check("b_after_split_line", 32'(b_line), 7);

    check("done_err_overlap", a_both + b_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corr_frame_rx.md
CORR_FRAME_RX -- requirements
Module: corr_frame_rx

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- RESOLUTION, 8, counter width in bits; SHALL be 8 or 16.
- MAX_DELAY, 50, maximum lag.
- DELAY_LINES, MAX_DELAY|1, lags per baseline.
- NUM_INPUTS, 8, antenna inputs.
- GAP_CYCLES, 4096, idle clk cycles that mark a frame boundary.
REQ-002 Derived values:
- NUM_CORRELATORS = NUM_INPUTS*(NUM_INPUTS-1)/2.
- N_WORDS = NUM_CORRELATORS*DELAY_LINES + NUM_INPUTS.
- FRAME_BYTES = N_WORDS*RESOLUTION/8 + 8.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- rx_data, in, 8, received UART byte.
- rx_valid, in, 1, one-cycle strobe, rx_data valid, already synchronous to clk.
- cnt_data, out, RESOLUTION, reassembled counter word.
- cnt_index, out, 16, word index 0..N_WORDS-1.
- cnt_valid, out, 1, one-cycle strobe for cnt_data/cnt_index.
- active_line, out, 4, trailer field.
- hdr_delay_lines, out, 8, trailer field.
- hdr_num_inputs, out, 8, trailer field.
- hdr_resolution, out, 8, trailer field.
- frame_done, out, 1, one-cycle strobe: good frame ended.
- frame_err, out, 1, one-cycle strobe: bad frame.
REQ-004 One clock, clk; reset is synchronous and active-high, port name reset.

Function
REQ-005 Frame byte order SHALL be: payload words 0..N_WORDS-1, each little-endian (LSB byte first), then 8 trailer bytes.
REQ-006 Trailer layout SHALL be: bytes 0-3 active_line (32-bit LE, bits 31:4 zero), byte 4 DELAY_LINES, byte 5 NUM_INPUTS, byte 6 RESOLUTION, byte 7 zero.
REQ-007 States SHALL be SYNC, PAYLOAD, TRAILER.
- SYNC: ignore bytes until GAP_CYCLES consecutive cycles pass with no rx_valid, then arm; the first rx_valid after arming enters PAYLOAD with byte counter 0.
REQ-008 PAYLOAD: on the last byte of word k, assert cnt_valid for one cycle on the next clk edge with cnt_index=k and the assembled word; after word N_WORDS-1, go to TRAILER.
REQ-009 TRAILER: capture the 8 bytes.
- On the 8th byte, compare bytes 4-6 against parameters and bytes 7 and 0-3 bits 31:4 against zero.
- Match: update the four hdr outputs and pulse frame_done the next cycle.
- Mismatch: pulse frame_err instead and leave hdr outputs unchanged.
- Either way, go to SYNC.
REQ-010 In PAYLOAD or TRAILER, a gap of GAP_CYCLES without rx_valid SHALL pulse frame_err, discard the partial frame and go to SYNC already armed.
REQ-011 A word split across a gap SHALL NOT produce cnt_valid.
REQ-012 The gap counter SHALL saturate at GAP_CYCLES and clear on every rx_valid.
REQ-013 rx_valid on consecutive cycles SHALL be accepted without loss; throughput is 1 byte/cycle.
REQ-014 frame_done and frame_err SHALL never assert in the same cycle.
REQ-015 cnt_data and cnt_index SHALL hold their last values while cnt_valid is low.

Reset
REQ-016 reset SHALL force:
- state SYNC, unarmed.
- gap counter 0, byte and word counters 0.
- cnt_valid=0, frame_done=0, frame_err=0.
- cnt_data=0, cnt_index=0, all hdr outputs 0.
REQ-017 reset mid-frame SHALL discard the partial frame with no frame_err pulse.
REQ-018 reset has priority over rx_valid in the same cycle.

Structure
REQ-019 A shared package SHALL hold:
- state enumeration.
- trailer byte offsets.
- the derived formulas for NUM_CORRELATORS, N_WORDS and FRAME_BYTES, shared with the transmit side.
REQ-020 One sub-module, gap_timer, SHALL implement the saturating idle counter and armed flag; the remainder is a single FSM with byte/word counters.

Verification
REQ-021 Required directed scenarios:
- Defaults; gap 4096 cycles; 1444-byte frame with word k = k mod 256, trailer 03 00 00 00 33 08 08 00 -> 1436 cnt_valid pulses, indices 0..1435, frame_done once, active_line=3, hdr_delay_lines=0x33.
- RESOLUTION=16; word 0 bytes 0x34,0x12 -> cnt_data=0x1234 at cnt_index=0.
- Trailer byte 5 = 0x07 -> frame_err pulse, no frame_done, hdr outputs unchanged.
- Bytes stop after 700 of 1444; 4096 idle cycles -> frame_err; a full frame sent immediately afterwards -> frame_done.
- Bytes arriving before the first gap after reset -> no cnt_valid; frame decodes correctly only after the gap.
- reset at byte 500 -> all outputs 0, no frame_err; the next frame after a gap decodes with frame_done.
